// File: rtl/fp16_result_collector_if.sv
// fp16_result_collector_if
//   Packed-word output stream of the FP16 result collector.
//   m_data  : packed word {newer result, older result}
//   m_valid : m_data holds a valid word
//   m_ready : consumer accepts m_data this cycle
//   master  : collector side (drives data/valid, samples ready)
//   slave   : consumer side (samples data/valid, drives ready)
interface fp16_result_collector_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] m_data;
  logic               m_valid;
  logic               m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fp16_result_collector.sv
// fp16_result_collector
//   Pairs consecutive FP16 results into 2*WIDTH-bit words, buffers them in a
//   first-word fall-through FIFO, and keeps NaN / Inf / total result counts.
//   Ports:
//     clk, reset          : single clock, synchronous active-high reset
//     fp16_d, out_valid   : result stream from the multiply-add stage (no backpressure)
//     flush               : emit a pending unpaired half as {0, half}
//     m_if (master)       : m_data / m_valid / m_ready output stream
//     level               : FIFO occupancy
//     overflow            : sticky, a packed word was dropped on a full FIFO
//     nan_cnt, inf_cnt    : saturating class counters
//     res_cnt             : wrapping count of accepted results
module fp16_result_collector #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         fp16_d,
  input  logic                     out_valid,
  input  logic                     flush,
  fp16_result_collector_if.master  m_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              nan_cnt,
  output logic [15:0]              inf_cnt,
  output logic [31:0]              res_cnt
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int DW      = 2 * WIDTH;
  localparam int MAN_W   = 10;
  localparam int EXP_MSB = WIDTH - 2;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Exponent all ones with a non-zero mantissa.
  function automatic logic is_nan(input logic [WIDTH-1:0] v);
    return (v[EXP_MSB:MAN_W] == 5'h1F) && (v[MAN_W-1:0] != 10'h000);
  endfunction

  // Exponent all ones with a zero mantissa (either sign).
  function automatic logic is_inf(input logic [WIDTH-1:0] v);
    return (v[EXP_MSB:MAN_W] == 5'h1F) && (v[MAN_W-1:0] == 10'h000);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'h0001;
  endfunction

  logic [WIDTH-1:0] half_q, half_d;
  logic             half_vld_q, half_vld_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      nan_cnt_q, nan_cnt_d;
  logic [15:0]      inf_cnt_q, inf_cnt_d;
  logic [31:0]      res_cnt_q, res_cnt_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic             push_s;
  logic [DW-1:0]    push_data_s;
  logic             pop_s;
  logic             full_s;
  logic             wr_en_s;
  logic             m_valid_s;

  // Reset gates the head so the consumer sees an empty stream during reset.
  assign m_valid_s    = !reset && (level_q != {LW{1'b0}});
  assign m_if.m_valid = m_valid_s;
  assign m_if.m_data  = m_valid_s ? mem_q[rd_ptr_q] : {DW{1'b0}};
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign nan_cnt      = nan_cnt_q;
  assign inf_cnt      = inf_cnt_q;
  assign res_cnt      = res_cnt_q;

  // Pairing, FIFO bookkeeping and counter next-state.
  always_comb begin
    half_d      = half_q;
    half_vld_d  = half_vld_q;
    push_s      = 1'b0;
    push_data_s = {fp16_d, half_q};

    if (out_valid) begin
      if (half_vld_q) begin
        // Completing a pair wins over flush.
        push_s      = 1'b1;
        push_data_s = {fp16_d, half_q};
        half_vld_d  = 1'b0;
      end else if (flush) begin
        push_s      = 1'b1;
        push_data_s = {{WIDTH{1'b0}}, fp16_d};
        half_vld_d  = 1'b0;
      end else begin
        half_d     = fp16_d;
        half_vld_d = 1'b1;
      end
    end else begin
      if (flush && half_vld_q) begin
        push_s      = 1'b1;
        push_data_s = {{WIDTH{1'b0}}, half_q};
        half_vld_d  = 1'b0;
      end else begin
        push_s = 1'b0;
      end
    end

    pop_s  = m_valid_s && m_if.m_ready;
    full_s = (level_q == FULL_LVL);
    // On a full FIFO a same-cycle pop frees the slot being written.
    wr_en_s = push_s && (!full_s || pop_s);
    overflow_d = overflow_q || (push_s && full_s && !pop_s);

    wr_ptr_d = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (out_valid) begin
      res_cnt_d = res_cnt_q + 32'd1;
      nan_cnt_d = is_nan(fp16_d) ? sat_inc(nan_cnt_q) : nan_cnt_q;
      inf_cnt_d = is_inf(fp16_d) ? sat_inc(inf_cnt_q) : inf_cnt_q;
    end else begin
      res_cnt_d = res_cnt_q;
      nan_cnt_d = nan_cnt_q;
      inf_cnt_d = inf_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_q     <= {WIDTH{1'b0}};
      half_vld_q <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
      overflow_q <= 1'b0;
      nan_cnt_q  <= 16'h0000;
      inf_cnt_q  <= 16'h0000;
      res_cnt_q  <= 32'h0000_0000;
    end else begin
      half_q     <= half_d;
      half_vld_q <= half_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      nan_cnt_q  <= nan_cnt_d;
      inf_cnt_q  <= inf_cnt_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  // FIFO storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

endmodule

// File: tb/tb_fp16_result_collector.sv
module tb_fp16_result_collector;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fp16_d;
  logic        out_valid;
  logic        flush;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] nan_cnt;
  logic [15:0] inf_cnt;
  logic [31:0] res_cnt;

  fp16_result_collector_if #(.WIDTH(WIDTH)) m_if ();

  fp16_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .fp16_d    (fp16_d),
    .out_valid (out_valid),
    .flush     (flush),
    .m_if      (m_if),
    .level     (level),
    .overflow  (overflow),
    .nan_cnt   (nan_cnt),
    .inf_cnt   (inf_cnt),
    .res_cnt   (res_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of packed words plus a pending half.
  logic [31:0] mq[$];
  bit          mdl_half;
  logic [15:0] mdl_halfv;
  bit          mdl_ovf;
  logic [15:0] mdl_nan;
  logic [15:0] mdl_inf;
  logic [31:0] mdl_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mdl_half  = 1'b0;
    mdl_halfv = 16'h0000;
    mdl_ovf   = 1'b0;
    mdl_nan   = 16'h0000;
    mdl_inf   = 16'h0000;
    mdl_res   = 32'h0;
  endtask

  task automatic model_update(input bit rst, input bit ov, input bit fl, input bit rdy,
                              input logic [15:0] d);
    bit          do_push;
    logic [31:0] word;
    do_push = 1'b0;
    word    = 32'h0;
    if (rst) begin
      model_clear();
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (ov) begin
        mdl_res = mdl_res + 32'd1;
        if (d[14:10] == 5'h1F && d[9:0] != 10'h0 && mdl_nan != 16'hFFFF) mdl_nan++;
        if (d[14:10] == 5'h1F && d[9:0] == 10'h0 && mdl_inf != 16'hFFFF) mdl_inf++;
      end
      if (ov && mdl_half) begin
        word = {d, mdl_halfv}; mdl_half = 1'b0; do_push = 1'b1;
      end else if (ov && fl) begin
        word = {16'h0000, d}; do_push = 1'b1;
      end else if (ov) begin
        mdl_halfv = d; mdl_half = 1'b1;
      end else if (fl && mdl_half) begin
        word = {16'h0000, mdl_halfv}; mdl_half = 1'b0; do_push = 1'b1;
      end
      if (do_push) begin
        if (mq.size() >= DEPTH) mdl_ovf = 1'b1;
        else mq.push_back(word);
      end
    end
  endtask

  task automatic check_outputs();
    chk("m_valid", m_if.m_valid, (mq.size() != 0));
    chk("m_data",  m_if.m_data,  (mq.size() != 0) ? mq[0] : 32'h0);
    chk("level",   level,        mq.size());
    chk("overflow", overflow,    mdl_ovf);
    chk("nan_cnt", nan_cnt,      mdl_nan);
    chk("inf_cnt", inf_cnt,      mdl_inf);
    chk("res_cnt", res_cnt,      mdl_res);
  endtask

  // One clock: drive at the falling edge, check before the rising edge, update model.
  task automatic step(input bit rst, input bit ov, input bit fl, input bit rdy,
                      input logic [15:0] d);
    reset       = rst;
    out_valid   = ov;
    flush       = fl;
    m_if.m_ready = rdy;
    fp16_d      = d;
    #1;
    if (rst) begin
      chk("rst_m_valid", m_if.m_valid, 1'b0);
      chk("rst_m_data",  m_if.m_data,  32'h0);
    end else begin
      check_outputs();
    end
    @(posedge clk);
    model_update(rst, ov, fl, rdy, d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  typedef struct {
    bit          ov;
    bit          fl;
    bit          rdy;
    logic [15:0] d;
    bit          e_valid;
    logic [31:0] e_data;
    int          e_level;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [15:0] v;
    logic [15:0] rd;
    bit          r_rst;

    // Directed pairing / flush / classification table; expectations after each edge.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h3C00, 1'b0, 32'h0000_0000, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h4000, 1'b1, 32'h4000_3C00, 1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 32'h0000_0000, 0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h3555, 1'b0, 32'h0000_0000, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 32'h0000_3555, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 32'h0000_0000, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 32'h0000_0000, 0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h5678, 1'b1, 32'h5678_1234, 1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b1, 32'h0000_AAAA, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 32'h0000_0000, 0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h7E00, 1'b0, 32'h0000_0000, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h7C00, 1'b1, 32'h7C00_7E00, 1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'hFC00, 1'b1, 32'h7C00_7E00, 1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h7C01, 1'b1, 32'h7C00_7E00, 2};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 32'h7C01_FC00, 1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 32'h0000_0000, 0};

    reset = 1'b1; out_valid = 1'b0; flush = 1'b0; fp16_d = 16'h0; m_if.m_ready = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();
    check_outputs();

    for (int i = 0; i < 16; i++) begin
      step(1'b0, vecs[i].ov, vecs[i].fl, vecs[i].rdy, vecs[i].d);
      chk($sformatf("vec%0d_valid", i), m_if.m_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_data", i),  m_if.m_data,  vecs[i].e_data);
      chk($sformatf("vec%0d_level", i), level,        vecs[i].e_level);
    end
    chk("tbl_nan_cnt", nan_cnt, 16'd2);
    chk("tbl_inf_cnt", inf_cnt, 16'd2);
    chk("tbl_res_cnt", res_cnt, 32'd10);

    // Overflow: 2*DEPTH+2 results with the consumer stalled.
    do_reset();
    for (int i = 0; i < 2*DEPTH+2; i++) begin
      v = 16'h0100 + 16'(i);
      step(1'b0, 1'b1, 1'b0, 1'b0, v);
    end
    chk("ovf_level", level, 4'd8);
    chk("ovf_flag", overflow, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("ovf_word%0d", k), m_if.m_data,
          {16'h0100 + 16'(2*k+1), 16'h0100 + 16'(2*k)});
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    end
    chk("ovf_drained", m_if.m_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);

    // Full FIFO: pair completes in the same cycle as a pop.
    do_reset();
    chk("ovf_cleared", overflow, 1'b0);
    for (int i = 0; i < 2*DEPTH; i++) begin
      v = 16'h2000 + 16'(i);
      step(1'b0, 1'b1, 1'b0, 1'b0, v);
    end
    chk("full_level", level, 4'd8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1111);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h2222);
    chk("fullpp_level", level, 4'd8);
    chk("fullpp_ovf", overflow, 1'b0);
    chk("fullpp_head", m_if.m_data, 32'h2003_2002);

    // Reset with words buffered and a pending half.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      v = 16'h3000 + 16'(i);
      step(1'b0, 1'b1, 1'b0, 1'b0, v);
    end
    chk("pre_rst_level", level, 4'd5);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h7C00);
    chk("post_rst_level", level, 4'd0);
    chk("post_rst_valid", m_if.m_valid, 1'b0);
    chk("post_rst_res", res_cnt, 32'd0);
    chk("post_rst_nan", nan_cnt, 16'd0);
    chk("post_rst_inf", inf_cnt, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hAAAA);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hBBBB);
    chk("fresh_pair", m_if.m_data, 32'hBBBB_AAAA);
    chk("fresh_level", level, 4'd1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       rd = {1'($urandom_range(0, 1)), 5'h1F, 10'h000};
        1:       rd = {1'($urandom_range(0, 1)), 5'h1F, 10'($urandom_range(1, 1023))};
        default: rd = 16'($urandom);
      endcase
      r_rst = ($urandom_range(0, 199) == 0);
      step(r_rst, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 4), rd);
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
